// File: rtl/nn_pll_pkg.sv
// ---------------------------------------------------------------------------
// nn_pll_pkg
// Shared definitions for the neural-network PLL phase path: the default width
// of the signed phase-error words, the clamp limits for that width, helper
// functions that derive the limits for any width, and the encoding of the
// phase-sampler state machine.
// ---------------------------------------------------------------------------
package nn_pll_pkg;

  // Width of the signed phase-error words fed to the network.
  localparam int ERR_W = 9;

  // Largest / smallest representable signed error for a given word width.
  function automatic int err_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int err_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Clamp limits for the default width (+255 / -256).
  localparam int ERR_MAX = (1 << (ERR_W - 1)) - 1;
  localparam int ERR_MIN = -(1 << (ERR_W - 1));

  // Phase-sampler states: waiting for a first edge, reference leading,
  // feedback leading, and the single reporting cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/nn_edge_det.sv
// ---------------------------------------------------------------------------
// nn_edge_det
// Rise detector for one clock-like input, producing a one-cycle pulse in the
// clk domain for every low-to-high transition.
//
// Configuration macro: NN_PHASE_SAMPLER_SYNC_EN
//   defined   : the input passes through a two-flop synchronizer first, so
//               the pulse lags the input by two extra clk cycles.
//   undefined : the input is edge-detected directly and must already be
//               synchronous to clk.
//
// Ports
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset, clears all history
//   sig_in in  level to watch
//   rise   out one-cycle pulse on a detected rising edge
// ---------------------------------------------------------------------------
module nn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

`ifdef NN_PHASE_SAMPLER_SYNC_EN
  logic sync1;
  logic sync2;
  logic prev;

  // Two metastability-settling stages, then one more flop holding the
  // previous synchronized level so a rise is "high now, low last cycle".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
`else
  logic prev;

  // The input is already clk-synchronous, so only the previous level is
  // remembered and the rise is seen in the same cycle the input goes high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= sig_in;
    end
  end

  assign rise = sig_in & ~prev;
`endif

endmodule

// File: rtl/nn_phase_sampler.sv
// ---------------------------------------------------------------------------
// nn_phase_sampler
// Measures the time, in clk cycles, between a reference edge and a divided
// DCO feedback edge and presents it as a signed phase error for the neural
// loop filter. Positive error: reference led. Negative error: feedback led.
// Errors beyond the word range, and leads that run out to TIMEOUT cycles,
// are clamped and flagged through err_sat.
//
// Configuration macro: NN_PHASE_SAMPLER_SYNC_EN (see nn_edge_det) selects
// synchronized or direct edge detection; the state machine is identical.
//
// Ports
//   clk       in  clock, all state changes on the rising edge
//   rst_n     in  synchronous active-low reset
//   en        in  measurement enable; low discards any measurement in flight
//   ref_in    in  reference clock
//   fb_in     in  divided DCO feedback clock
//   err_cur   out signed current phase error (network input 0)
//   err_prev  out signed previous phase error (network input 1)
//   err_valid out one-cycle pulse when err_cur/err_prev have just updated
//   err_sat   out last err_cur was clamped or produced by timeout
// ---------------------------------------------------------------------------
module nn_phase_sampler #(
  parameter int ERR_W   = nn_pll_pkg::ERR_W,
  parameter int TIMEOUT = 300
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic signed [ERR_W-1:0] err_cur,
  output logic signed [ERR_W-1:0] err_prev,
  output logic                    err_valid,
  output logic                    err_sat
);

  import nn_pll_pkg::*;

  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int POS_LIM = err_max(ERR_W);
  localparam int NEG_MAG = -err_min(ERR_W);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [31:0]             cnt_ext;
  logic                    ref_rise;
  logic                    fb_rise;
  logic                    timed_out;
  logic                    pos_clamp;
  logic                    neg_clamp;
  logic signed [ERR_W-1:0] pos_err;
  logic signed [ERR_W-1:0] neg_err;
  logic signed [ERR_W-1:0] err_new;
  logic                    sat_new;
  logic                    load;

  nn_edge_det u_ref_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (ref_in),
    .rise   (ref_rise)
  );

  nn_edge_det u_fb_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (fb_in),
    .rise   (fb_rise)
  );

  assign cnt_ext   = 32'(cnt);
  assign timed_out = (cnt_ext >= 32'(TIMEOUT));

  // Candidate errors for both lead directions. The count is the lead in
  // cycles; it is saturated into the signed word and the clamp remembered.
  always_comb begin
    pos_clamp = (cnt_ext > 32'(POS_LIM));
    neg_clamp = (cnt_ext > 32'(NEG_MAG));
    pos_err   = pos_clamp ? ERR_W'(POS_LIM) : ERR_W'(cnt_ext);
    neg_err   = neg_clamp ? ERR_W'(err_min(ERR_W)) : ERR_W'(32'd0 - cnt_ext);
  end

  // Next-state logic. A lead ends on the opposite edge, or on timeout; a
  // repeated edge of the leading clock means a slipped cycle, so the lead
  // restarts from that edge. Dropping en overrides everything and throws
  // the measurement away without touching the outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    err_new   = '0;
    sat_new   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          state_nxt = DONE;
          load      = 1'b1;
        end else if (ref_rise) begin
          state_nxt = LEAD_REF;
          cnt_nxt   = CNT_W'(1);
        end else if (fb_rise) begin
          state_nxt = LEAD_FB;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LEAD_REF: begin
        if (fb_rise || timed_out) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          load      = 1'b1;
          err_new   = pos_err;
          sat_new   = pos_clamp | (timed_out & ~fb_rise);
        end else if (ref_rise) begin
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      LEAD_FB: begin
        if (ref_rise || timed_out) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          load      = 1'b1;
          err_new   = neg_err;
          sat_new   = neg_clamp | (timed_out & ~ref_rise);
        end else if (fb_rise) begin
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      load      = 1'b0;
    end
  end

  // State, lead counter and the error registers. The error words only move
  // on the edge that enters DONE, so they stay stable between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err_cur  <= '0;
      err_prev <= '0;
      err_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        err_prev <= err_cur;
        err_cur  <= err_new;
        err_sat  <= sat_new;
      end
    end
  end

  assign err_valid = (state == DONE);

endmodule

// File: tb/tb_nn_phase_sampler.sv
// ---------------------------------------------------------------------------
// tb_nn_phase_sampler
// Self-checking bench for nn_phase_sampler. A timestamp-based reference
// model tracks which clock leads and since which cycle; a compare process
// checks every output on every cycle after reset. Directed scenarios pin
// the model with literal expectations, then randomized edge streams with
// occasional reset and enable drops exercise the rest.
// ---------------------------------------------------------------------------
module tb_nn_phase_sampler;

  localparam int ERR_W   = 9;
  localparam int TIMEOUT = 300;
  localparam int HI      = 255;
  localparam int LO      = -256;
`ifdef NN_PHASE_SAMPLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    ref_in;
  logic                    fb_in;
  logic signed [ERR_W-1:0] err_cur;
  logic signed [ERR_W-1:0] err_prev;
  logic                    err_valid;
  logic                    err_sat;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  // Reference model state: mode 0 waiting, 1 a lead is running, 2 reporting.
  int   mode = 0;
  int   dir = 0;
  int   startCyc = 0;
  int   cyc = 0;
  int   expCur = 0;
  int   expPrev = 0;
  int   expSat = 0;
  int   expValid = 0;
  bit   modelReady = 1'b0;
  logic [3:0] rHist = '0;
  logic [3:0] fHist = '0;

  nn_phase_sampler #(
    .ERR_W   (ERR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .err_cur   (err_cur),
    .err_prev  (err_prev),
    .err_valid (err_valid),
    .err_sat   (err_sat)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Record a finished measurement: the error is the signed lead, saturated
  // to the word range; a timeout always counts as saturated.
  task automatic report(input int e, input bit forced);
    expPrev = expCur;
    if (e > HI) begin
      expCur = HI;
      expSat = 1;
    end else if (e < LO) begin
      expCur = LO;
      expSat = 1;
    end else begin
      expCur = e;
      expSat = forced ? 1 : 0;
    end
    expValid = 1;
    mode     = 2;
  endtask

  // Reference model, advanced on every rising clock edge. Rises are taken
  // from the sampled input history (delayed by the synchronizer depth when
  // that option is built in); the lead length is the distance in cycles
  // between the leading edge and now.
  always @(posedge clk) begin : modelProc
    logic [3:0] rNow;
    logic [3:0] fNow;
    bit rr;
    bit fr;
    bit opp;
    bit same;
    int age;
    cyc++;
    rNow = {rHist[2:0], ref_in};
    fNow = {fHist[2:0], fb_in};
    rr   = rNow[LAT] & ~rNow[LAT+1];
    fr   = fNow[LAT] & ~fNow[LAT+1];
    if (!rst_n) begin
      rHist = '0;
      fHist = '0;
      mode = 0;
      expCur = 0;
      expPrev = 0;
      expSat = 0;
      expValid = 0;
      modelReady = 1'b1;
    end else begin
      rHist = rNow;
      fHist = fNow;
      expValid = 0;
      if (!en) begin
        mode = 0;
      end else if (mode == 2) begin
        mode = 0;
      end else if (mode == 0) begin
        if (rr && fr) begin
          report(0, 1'b0);
        end else if (rr || fr) begin
          mode = 1;
          dir = rr ? 1 : -1;
          startCyc = cyc;
        end
      end else begin
        age  = cyc - startCyc;
        opp  = (dir > 0) ? fr : rr;
        same = (dir > 0) ? rr : fr;
        if (opp) begin
          report(dir * age, 1'b0);
        end else if (age >= TIMEOUT) begin
          report(dir * age, 1'b1);
        end else if (same) begin
          startCyc = cyc;
        end
      end
    end
  end

  // Compare process: every falling edge after the first reset, all outputs
  // against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("err_cur", int'(err_cur), expCur);
      checkOutput("err_prev", int'(err_prev), expPrev);
      checkOutput("err_sat", int'(err_sat), expSat);
      checkOutput("err_valid", int'(err_valid), expValid);
      if (err_valid === 1'b1) validCount++;
    end
  end

  // Drive one cycle of clock levels at the falling edge.
  task automatic applyStimulus(input logic r, input logic f);
    @(negedge clk);
    ref_in = r;
    fb_in  = f;
  endtask

  // Idle the inputs until err_valid shows up; waited is the number of
  // falling edges it took, or -1 when the budget ran out.
  task automatic waitValid(input int budget, output int waited);
    waited = 0;
    while (waited < budget) begin
      @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      waited++;
      if (err_valid === 1'b1) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL waitValid: no err_valid within %0d cycles", budget);
    waited = -1;
  endtask

  // Safety net in case the run never reaches its own end.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed results, then random streams.
  initial begin
    int w;
    int v0;
    int dens[10] = '{2, 10, 50, 200, 1, 30, 500, 5, 100, 3};
    rst_n  = 1'b0;
    en     = 1'b1;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset err_cur", int'(err_cur), 0);
    checkOutput("reset err_prev", int'(err_prev), 0);
    checkOutput("reset err_valid", int'(err_valid), 0);
    checkOutput("reset err_sat", int'(err_sat), 0);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] ref leads fb by 10 cycles");
    applyStimulus(1'b1, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitValid(5, w);
    checkOutput("lead10 latency", w, 1);
    checkOutput("lead10 err_cur", int'(err_cur), 10);
    checkOutput("lead10 err_sat", int'(err_sat), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("lead10 pulse width", int'(err_valid), 0);

    $display("[TB] fb leads ref by 37 cycles");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (36) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitValid(5, w);
    checkOutput("lag37 err_cur", int'(err_cur), -37);
    checkOutput("lag37 err_prev", int'(err_prev), 10);

    $display("[TB] simultaneous edges");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    waitValid(5, w);
    checkOutput("coincident latency", w, 1);
    checkOutput("coincident err_cur", int'(err_cur), 0);
    checkOutput("coincident err_prev", int'(err_prev), -37);

    $display("[TB] ref lead with no fb edge");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitValid(400, w);
    checkOutput("timeout latency", w, TIMEOUT + 1);
    checkOutput("timeout err_cur", int'(err_cur), 255);
    checkOutput("timeout err_sat", int'(err_sat), 1);

    $display("[TB] fb leads by 270 cycles");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    repeat (269) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitValid(5, w);
    checkOutput("lag270 err_cur", int'(err_cur), -256);
    checkOutput("lag270 err_sat", int'(err_sat), 1);

    $display("[TB] reset in the middle of a lead");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v0 = validCount;
    checkOutput("midreset err_cur", int'(err_cur), 0);
    checkOutput("midreset err_prev", int'(err_prev), 0);
    checkOutput("midreset err_sat", int'(err_sat), 0);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("midreset no pulse", validCount - v0, 0);
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitValid(5, w);
    checkOutput("after reset err_cur", int'(err_cur), 4);

    $display("[TB] enable drop discards a lead");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    v0 = validCount;
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("en drop no pulse", validCount - v0, 0);
    checkOutput("en drop holds err_cur", int'(err_cur), 4);
    applyStimulus(1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitValid(5, w);
    checkOutput("after en drop err_cur", int'(err_cur), -6);

    $display("[TB] randomized edge streams");
    for (int seg = 0; seg < 10; seg++) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        ref_in = ($urandom_range(0, 999) < dens[seg]);
        fb_in  = ($urandom_range(0, 999) < dens[seg]);
        en     = ($urandom_range(0, 499) != 0);
        rst_n  = ($urandom_range(0, 999) != 0);
      end
    end
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) applyStimulus(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
